// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: synchronizes rx, qualifies the start bit, samples data mid-bit LSB-first,
// checks the stop bit and holds each word until acknowledged. Define UART_RX_PARITY_EN for a parity bit.
module uart_rx_deserializer #(
    parameter int WORD_SIZE    = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 rx_ack,
    output logic                 rx_valid,
    output logic [WORD_SIZE-1:0] rx_data,
    output logic                 frame_err,
    output logic                 overrun,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 busy
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(WORD_SIZE + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_HALF = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(WORD_SIZE - 1);

    if (WORD_SIZE < 5 || WORD_SIZE > 9) begin : g_bad_word_size
        $error("uart_rx_deserializer: WORD_SIZE must be 5..9");
    end
    if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
        $error("uart_rx_deserializer: CLKS_PER_BIT must be >= 4");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
        $error("uart_rx_deserializer: PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        RECOVER
    } state_t;

    state_t                 state_q, state_d;
    logic                   sync1_q, sync2_q;
    logic                   rxS;
    logic [BW-1:0]          baudCnt_q, baudCnt_d;
    logic [IW-1:0]          bitIdx_q, bitIdx_d;
    logic [WORD_SIZE-1:0]   shift_q, shift_d;
    logic [WORD_SIZE-1:0]   rxData_q, rxData_d;
    logic                   rxValid_q, rxValid_d;
    logic                   frameErr_q, frameErr_d;
    logic                   overrun_q, overrun_d;
    logic                   deliver;
`ifdef UART_RX_PARITY_EN
    localparam logic PARITY_SENSE = PARITY_ODD[0];
    logic                   parityBad_q, parityBad_d;
    logic                   parityErr_q, parityErr_d;
`endif

    assign rxS = sync2_q;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            baudCnt_q  <= '0;
            bitIdx_q   <= '0;
            shift_q    <= '0;
            rxData_q   <= '0;
            rxValid_q  <= 1'b0;
            frameErr_q <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parityBad_q <= 1'b0;
            parityErr_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baudCnt_q  <= baudCnt_d;
            bitIdx_q   <= bitIdx_d;
            shift_q    <= shift_d;
            rxData_q   <= rxData_d;
            rxValid_q  <= rxValid_d;
            frameErr_q <= frameErr_d;
            overrun_q  <= overrun_d;
`ifdef UART_RX_PARITY_EN
            parityBad_q <= parityBad_d;
            parityErr_q <= parityErr_d;
`endif
        end
    end

    // The start bit is checked half a period in, so every later sample lands mid-bit.
    always_comb begin
        state_d    = state_q;
        baudCnt_d  = (baudCnt_q == BAUD_LAST) ? '0 : baudCnt_q + 1'b1;
        bitIdx_d   = bitIdx_q;
        shift_d    = shift_q;
        rxData_d   = rxData_q;
        rxValid_d  = rxValid_q;
        frameErr_d = 1'b0;
        overrun_d  = 1'b0;
        deliver    = 1'b0;
`ifdef UART_RX_PARITY_EN
        parityBad_d = parityBad_q;
        parityErr_d = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                baudCnt_d = '0;
                if (!rxS) begin
                    state_d = START;
                end
            end
            START: begin
                if (baudCnt_q == BAUD_HALF) begin
                    baudCnt_d = '0;
                    if (!rxS) begin
                        state_d  = DATA;
                        bitIdx_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (baudCnt_q == BAUD_LAST) begin
                    shift_d  = {rxS, shift_q[WORD_SIZE-1:1]};
                    bitIdx_d = bitIdx_q + 1'b1;
                    if (bitIdx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (baudCnt_q == BAUD_LAST) begin
                    parityBad_d = ((^shift_q) ^ rxS) != PARITY_SENSE;
                    state_d     = STOP;
                end
            end
`endif
            STOP: begin
                if (baudCnt_q == BAUD_LAST) begin
                    if (rxS) begin
                        deliver = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frameErr_d = 1'b1;
                        state_d    = RECOVER;
                    end
                end
            end
            RECOVER: begin
                baudCnt_d = '0;
                if (rxS) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                baudCnt_d = '0;
            end
        endcase

        // A same-cycle ack counts as consuming the old word, so no overrun then.
        if (deliver) begin
            rxData_d  = shift_q;
            rxValid_d = 1'b1;
            overrun_d = rxValid_q && !rx_ack;
`ifdef UART_RX_PARITY_EN
            parityErr_d = parityBad_q;
`endif
        end else if (rx_ack) begin
            rxValid_d = 1'b0;
        end
    end

    assign rx_valid  = rxValid_q;
    assign rx_data   = rxData_q;
    assign frame_err = frameErr_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = parityErr_q;
`endif

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed testbench for uart_rx_deserializer at CLKS_PER_BIT=16, WORD_SIZE=8.
// Frame table in a loop, plus hand-written sequences for timing, overrun, break and reset corners.
module tb_uart_rx_deserializer;

    localparam int CPB = 16;
    localparam int WS  = 8;

    logic          clk;
    logic          rst;
    logic          rx;
    logic          rx_ack;
    logic          rx_valid;
    logic [WS-1:0] rx_data;
    logic          frame_err;
    logic          overrun;
    logic          busy;
`ifdef UART_RX_PARITY_EN
    logic          parityErr;
`endif

    int testCount = 0;
    int failCount = 0;

    int   cycle     = 0;
    int   ferrCount = 0;
    int   ovrCount  = 0;
    int   perrCount = 0;
    int   lastRise  = -1;
    logic prevValid = 1'b0;

    uart_rx_deserializer #(
        .WORD_SIZE   (WS),
        .CLKS_PER_BIT(CPB),
        .PARITY_ODD  (0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rx_ack   (rx_ack),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .frame_err(frame_err),
        .overrun  (overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err(parityErr),
`endif
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter plus pulse counters, so each pulse is measured as a count of high cycles.
    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        ferrCount <= ferrCount + int'(frame_err);
        ovrCount  <= ovrCount + int'(overrun);
`ifdef UART_RX_PARITY_EN
        perrCount <= perrCount + int'(parityErr);
`endif
        if (rx_valid === 1'b1 && prevValid !== 1'b1) lastRise <= cycle;
        prevValid <= rx_valid;
    end

    typedef struct {
        logic [7:0] data;
        logic       stopBit;
        logic [7:0] expData;
        logic       expValid;
        int         expFerr;
    } vec_t;

    vec_t vecs[6];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives one frame; leaves rx at the stop-bit level so back-to-back frames need no gap.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input logic parityBit);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < WS; i++) begin
            rx = data[i];
            tick(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rx = parityBit;
        tick(CPB);
`else
        if (parityBit) begin
        end
`endif
        rx = stopBit;
        tick(CPB);
    endtask

    task automatic ackWord();
        rx_ack = 1'b1;
        tick(1);
        rx_ack = 1'b0;
        tick(1);
    endtask

    initial begin
        int f0, o0, p0, start;

        vecs[0] = '{8'h55, 1'b1, 8'h55, 1'b1, 0};
        vecs[1] = '{8'hA3, 1'b1, 8'hA3, 1'b1, 0};
        vecs[2] = '{8'h00, 1'b1, 8'h00, 1'b1, 0};
        vecs[3] = '{8'h81, 1'b0, 8'h00, 1'b0, 1};
        vecs[4] = '{8'hFF, 1'b1, 8'hFF, 1'b1, 0};
        vecs[5] = '{8'h6E, 1'b1, 8'h6E, 1'b1, 0};

        rst    = 1'b1;
        rx     = 1'b1;
        rx_ack = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);

        checkOutput("reset rx_valid", 32'(rx_valid), 32'd0);
        checkOutput("reset rx_data", 32'(rx_data), 32'd0);
        checkOutput("reset frame_err", 32'(frame_err), 32'd0);
        checkOutput("reset overrun", 32'(overrun), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);

        // 0x55: rx_valid rises 8+9*16+1+2 = 155 cycles after rx falls and holds until ack.
        start = cycle;
        applyStimulus(8'h55, 1'b1, 1'b0);
        tick(20);
        checkOutput("latency 0x55", 32'(lastRise - start), 32'd155);
        checkOutput("hold rx_valid", 32'(rx_valid), 32'd1);
        checkOutput("hold rx_data", 32'(rx_data), 32'h55);
        rx_ack = 1'b1;
        tick(1);
        rx_ack = 1'b0;
        checkOutput("ack clears rx_valid", 32'(rx_valid), 32'd0);
        tick(2);
        checkOutput("ack while idle ignored", 32'(rx_valid), 32'd0);

        for (int i = 0; i < 6; i++) begin
            ackWord();
            f0 = ferrCount;
            o0 = ovrCount;
            applyStimulus(vecs[i].data, vecs[i].stopBit, ^vecs[i].data);
            rx = 1'b1;
            tick(4);
            checkOutput($sformatf("vec%0d rx_valid", i), 32'(rx_valid), 32'(vecs[i].expValid));
            if (vecs[i].expValid)
                checkOutput($sformatf("vec%0d rx_data", i), 32'(rx_data), 32'(vecs[i].expData));
            checkOutput($sformatf("vec%0d frame_err", i), 32'(ferrCount - f0), 32'(vecs[i].expFerr));
            checkOutput($sformatf("vec%0d overrun", i), 32'(ovrCount - o0), 32'd0);
            checkOutput($sformatf("vec%0d busy", i), 32'(busy), 32'd0);
        end

        // A 5-cycle low glitch is rejected at the half-bit start check.
        ackWord();
        f0 = ferrCount;
        rx = 1'b0;
        tick(5);
        rx = 1'b1;
        checkOutput("glitch busy", 32'(busy), 32'd1);
        tick(20);
        checkOutput("glitch idle", 32'(busy), 32'd0);
        checkOutput("glitch rx_valid", 32'(rx_valid), 32'd0);
        checkOutput("glitch frame_err", 32'(ferrCount - f0), 32'd0);

        // Bad stop bit followed by a held-low break: exactly one frame_err, busy until release.
        f0 = ferrCount;
        applyStimulus(8'hA3, 1'b0, 1'b0);
        tick(40);
        checkOutput("break busy", 32'(busy), 32'd1);
        checkOutput("break frame_err", 32'(ferrCount - f0), 32'd1);
        checkOutput("break rx_valid", 32'(rx_valid), 32'd0);
        rx = 1'b1;
        tick(4);
        checkOutput("break released", 32'(busy), 32'd0);
        checkOutput("break single pulse", 32'(ferrCount - f0), 32'd1);

        // Back-to-back without ack: second word overwrites and overrun pulses once.
        o0 = ovrCount;
        applyStimulus(8'h11, 1'b1, 1'b0);
        applyStimulus(8'h22, 1'b1, 1'b0);
        tick(4);
        checkOutput("b2b rx_data", 32'(rx_data), 32'h22);
        checkOutput("b2b rx_valid", 32'(rx_valid), 32'd1);
        checkOutput("b2b overrun", 32'(ovrCount - o0), 32'd1);

        // Same again, with rx_ack in the delivery cycle of the second word.
        ackWord();
        o0 = ovrCount;
        applyStimulus(8'h11, 1'b1, 1'b0);
        fork
            applyStimulus(8'h22, 1'b1, 1'b0);
            begin
                tick(154);
                rx_ack = 1'b1;
                tick(1);
                rx_ack = 1'b0;
            end
        join
        tick(4);
        checkOutput("ack-on-deliver rx_data", 32'(rx_data), 32'h22);
        checkOutput("ack-on-deliver rx_valid", 32'(rx_valid), 32'd1);
        checkOutput("ack-on-deliver overrun", 32'(ovrCount - o0), 32'd0);

        // Reset in the middle of 0xFF's data bits abandons it; the following frame is clean.
        fork
            applyStimulus(8'hFF, 1'b1, 1'b0);
            begin
                tick(60);
                rst = 1'b1;
                tick(2);
                rst = 1'b0;
            end
        join
        tick(4);
        checkOutput("abort rx_valid", 32'(rx_valid), 32'd0);
        checkOutput("abort rx_data", 32'(rx_data), 32'd0);
        checkOutput("abort busy", 32'(busy), 32'd0);
        applyStimulus(8'h3C, 1'b1, 1'b0);
        tick(4);
        checkOutput("after abort rx_data", 32'(rx_data), 32'h3C);
        checkOutput("after abort rx_valid", 32'(rx_valid), 32'd1);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones, so parity bit 0 is wrong and 1 is right.
        ackWord();
        p0 = perrCount;
        applyStimulus(8'h07, 1'b1, 1'b0);
        tick(4);
        checkOutput("parity bad rx_data", 32'(rx_data), 32'h07);
        checkOutput("parity bad pulse", 32'(perrCount - p0), 32'd1);
        ackWord();
        p0 = perrCount;
        applyStimulus(8'h07, 1'b1, 1'b1);
        tick(4);
        checkOutput("parity good rx_data", 32'(rx_data), 32'h07);
        checkOutput("parity good no pulse", 32'(perrCount - p0), 32'd0);
`else
        p0 = perrCount;
        checkOutput("no parity pulses", 32'(p0), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
- Receive-side serial front end that feeds the UART controller's RX ring buffer.
- Synchronizes the asynchronous rx line, detects and qualifies the start bit, samples each data bit mid-period LSB-first, and checks the stop bit.
- Presents each completed word on a level data-valid flag, held until the controller acknowledges it.
- Flags framing errors and overruns as single-cycle pulses.

Parameters:
- WORD_SIZE, 8, data bits per frame (5..9).
- CLKS_PER_BIT, 434, clk cycles per bit period (50 MHz / 115200); must be >= 4.
- PARITY_ODD, 0, parity sense when UART_RX_PARITY_EN is defined (0 = even, 1 = odd).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rx  in  1  asynchronous serial line, idle high
- rx_ack  in  1  controller has consumed rx_data; clears rx_valid
- rx_valid  out  1  word available; level, held until rx_ack
- rx_data  out  WORD_SIZE  received word; stable while rx_valid=1
- frame_err  out  1  1-cycle pulse: stop bit sampled low
- overrun  out  1  1-cycle pulse: new word completed while previous was unacknowledged
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset:
  - Synchronizer flops reset to 1; state IDLE; counters 0.
  - Reset values: rx_valid=0, rx_data=0, frame_err=0, overrun=0, busy=0.
  - Reset mid-frame abandons the frame; no partial word is ever presented.
- Synchronizer: 2-flop on rx giving rx_s; 2-cycle latency. All decisions use rx_s.
- Counters:
  - baud_cnt is $clog2(CLKS_PER_BIT) bits wide, counts 0..CLKS_PER_BIT-1 and wraps to 0.
  - bit_idx is $clog2(WORD_SIZE+1) bits wide.
- FSM states and transitions:
  - IDLE: rx_s==0 -> START, baud_cnt=0.
  - START: at baud_cnt==CLKS_PER_BIT/2-1, sample rx_s.
    - 0 -> DATA, baud_cnt=0, bit_idx=0.
    - 1 -> IDLE (glitch rejected, no flags).
  - DATA: at baud_cnt==CLKS_PER_BIT-1, shift rx_s into shift register at MSB, right-shifting, so the first bit lands in bit 0 after WORD_SIZE shifts. Increment bit_idx. After the WORD_SIZE-th sample -> STOP (or PARITY if enabled).
  - STOP: at baud_cnt==CLKS_PER_BIT-1, sample rx_s.
    - 1 -> deliver word (see below), then IDLE.
    - 0 -> frame_err pulse, word discarded, -> RECOVER.
  - RECOVER: wait for rx_s==1, then IDLE. A held-low break line yields exactly one frame_err.
- Delivery, in the cycle after the stop sample:
  - rx_data <= shift register; rx_valid <= 1.
  - If rx_valid already 1 and rx_ack==0 in the delivery cycle: rx_data is overwritten and overrun pulses.
- Ack:
  - rx_ack while rx_valid=1 clears rx_valid next cycle.
  - rx_ack while rx_valid=0 is ignored.
  - rx_ack and delivery in the same cycle: new word loaded, rx_valid stays 1, no overrun.
- Latency: rx_valid rises 1 cycle after the stop-bit sample point. That sample point is (CLKS_PER_BIT/2) + (WORD_SIZE+1)*CLKS_PER_BIT cycles after rx_s falls.
- Back-to-back frames: IDLE is re-entered mid stop bit, so the next falling edge is caught with no gap required.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - PARITY state inserted after DATA, one bit period long.
  - Sampled bit is XORed with the data bits; PARITY_ODD selects the sense.
  - Mismatch: word is still delivered, and a parity_err output (1 bit, 1-cycle pulse) pulses in the delivery cycle.
  - Stop check is unchanged.
- Not defined: no PARITY state and no parity_err port; the frame is start + WORD_SIZE + stop.

Test Plan (CLKS_PER_BIT=16, WORD_SIZE=8):
- Frame 0x55, stop=1, rx_ack held 0 -> rx_valid=1, rx_data=0x55, 8+9*16+1+2 cycles after rx falls; stays set until rx_ack, then 0 next cycle.
- rx low for 5 cycles then high -> returns to IDLE, rx_valid=0, frame_err=0.
- Frame 0xA3 with stop bit 0, line then low 40 cycles -> one frame_err pulse, rx_valid=0, busy until rx high.
- Frames 0x11 then 0x22 back-to-back, no ack -> rx_data=0x22, one overrun pulse. Repeat with rx_ack in the 0x22 delivery cycle -> rx_data=0x22, rx_valid=1, no overrun.
- rst asserted mid-DATA of 0xFF, then frame 0x3C -> nothing delivered for 0xFF, rx_data=0x3C, rx_valid=1.
- UART_RX_PARITY_EN, PARITY_ODD=0, frame 0x07 with parity bit 0 -> rx_data=0x07, parity_err pulses once; with parity bit 1 -> no pulse.
